// File: rtl/sword_arbiter.sv
// sword_arbiter: hands one shared sword to one of N_PLAYERS requesters at a time.
// The grant rotates round-robin, and there is a mandatory one-cycle cooldown between holders.
// Optional feature macro: SWORD_ARB_TIMEOUT_EN. When it is defined, the sword is taken
// back after HOLD_MAX cycles and 'forced' pulses during the cooldown that follows.
// The reset port 'reset' is asynchronous and active-low.
module sword_arbiter #(
  parameter int N_PLAYERS = 4,
  parameter int HOLD_MAX  = 15,
  parameter int ID_W      = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_PLAYERS-1:0] req,
  input  logic [N_PLAYERS-1:0] rel,
  output logic [N_PLAYERS-1:0] grant,
  output logic                 v,
  output logic [ID_W-1:0]      holder_id,
  output logic                 forced
);

  typedef enum logic [1:0] {IDLE, HELD, COOL} state_t;

  state_t                 state_q, state_d;
  logic [N_PLAYERS-1:0]   grant_q, grant_d;
  logic                   v_q, v_d;
  logic [ID_W-1:0]        holder_q, holder_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   forced_q, forced_d;

  logic [N_PLAYERS-1:0]   req_rot;
  logic                   found;
  logic [ID_W-1:0]        winner;
  logic [ID_W-1:0]        rr_next;
  logic                   rel_holder;

`ifdef SWORD_ARB_TIMEOUT_EN
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
`endif

  if (HOLD_MAX < 1) begin : g_hold_max_check
    $error("sword_arbiter: HOLD_MAX must be >= 1");
  end

  // Rotate requests so that bit 0 is the player at rr_ptr, then take the lowest set bit
  always_comb begin
    req_rot = N_PLAYERS'({req, req} >> rr_ptr_q);
    found   = 1'b0;
    winner  = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (!found && req_rot[i]) begin
        found  = 1'b1;
        winner = ((int'(rr_ptr_q) + i) >= N_PLAYERS) ? ID_W'(int'(rr_ptr_q) + i - N_PLAYERS)
                                                    : ID_W'(int'(rr_ptr_q) + i);
      end
    end
  end

  // The grant is one-hot on the holder, so masking rel with it honours only the holder's bit
  always_comb begin
    rel_holder = |(rel & grant_q);
    rr_next    = (holder_q == ID_W'(N_PLAYERS - 1)) ? '0 : holder_q + ID_W'(1);
  end

  // Next-state and registered-output logic for the IDLE/HELD/COOL sequence
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    holder_d = holder_q;
    rr_ptr_d = rr_ptr_q;
    forced_d = 1'b0;
`ifdef SWORD_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (found) begin
          state_d  = HELD;
          grant_d  = N_PLAYERS'(1) << winner;
          holder_d = winner;
`ifdef SWORD_ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      HELD: begin
        if (rel_holder) begin
          state_d  = COOL;
          grant_d  = '0;
          rr_ptr_d = rr_next;
        end
`ifdef SWORD_ARB_TIMEOUT_EN
        else if (hold_cnt_q == CNT_W'(HOLD_MAX - 1)) begin
          state_d  = COOL;
          grant_d  = '0;
          rr_ptr_d = rr_next;
          forced_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
`endif
      end
      COOL: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    v_d = |grant_d;
  end

  // State and output registers, cleared immediately when reset goes low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      v_q      <= 1'b0;
      holder_q <= '0;
      rr_ptr_q <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      v_q      <= v_d;
      holder_q <= holder_d;
      rr_ptr_q <= rr_ptr_d;
      forced_q <= forced_d;
    end
  end

`ifdef SWORD_ARB_TIMEOUT_EN
  // Hold counter that runs while the sword is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  assign grant     = grant_q;
  assign v         = v_q;
  assign holder_id = holder_q;
  assign forced    = forced_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));
  a_v_matches:     assert property (@(posedge clk) disable iff (!reset) v == |grant);
  a_no_direct_hop: assert property (@(posedge clk) disable iff (!reset)
                     ((grant != '0) && ($past(grant) != '0)) |-> (grant == $past(grant)));

endmodule

// File: tb/tb_sword_arbiter.sv
// Testbench for sword_arbiter, with N_PLAYERS=4 and HOLD_MAX=8.
// It runs a directed vector table, hand-written timeout and async-reset sequences, and then
// random traffic. The random traffic is checked against a simple model of holder, cooldown
// gap and round-robin pointer.
module tb_sword_arbiter;
  localparam int N = 4;
  localparam int HM = 8;
`ifdef SWORD_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] rel = '0;
  logic [N-1:0] grant;
  logic         v;
  logic [1:0]   holder_id;
  logic         forced;

  int checks = 0;
  int errors = 0;

  int m_holder, m_last, m_rr, m_gap, m_held;
  bit m_forced;

  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] grant;
    logic       v;
    logic [1:0] holder;
    logic       forced;
  } vec_t;

  vec_t tbl[18];

  sword_arbiter #(.N_PLAYERS(N), .HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset), .req(req), .rel(rel),
    .grant(grant), .v(v), .holder_id(holder_id), .forced(forced)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_holder = -1; m_last = 0; m_rr = 0; m_gap = 0; m_held = 0; m_forced = 1'b0;
  endtask

  // One clock edge of the reference model: an active holder, a pending cooldown, or arbitration
  task automatic model_step(input logic [3:0] r, input logic [3:0] l);
    if (m_holder >= 0) begin
      if (l[m_holder] || (TO_EN && m_held >= HM)) begin
        m_forced = !l[m_holder];
        m_rr     = (m_holder + 1) % N;
        m_holder = -1;
        m_gap    = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      m_forced = 1'b0;
    end else begin
      m_forced = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_holder < 0 && r[(m_rr + i) % N]) begin
          m_holder = (m_rr + i) % N;
          m_last   = m_holder;
          m_held   = 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
    req = r;
    rel = l;
    @(posedge clk);
    model_step(r, l);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic ev,
                             input logic [1:0] eh, input logic ef);
    checks++;
    if (grant !== eg || v !== ev || holder_id !== eh || forced !== ef) begin
      errors++;
      $display("[TB] FAIL %s: got grant=%b v=%b holder=%0d forced=%b, expected grant=%b v=%b holder=%0d forced=%b",
               name, grant, v, holder_id, forced, eg, ev, eh, ef);
    end
  endtask

  task automatic checkModel(input string name);
    logic [3:0] eg;
    eg = (m_holder >= 0) ? 4'(1 << m_holder) : 4'b0000;
    checkOutput(name, eg, |eg, 2'(m_last), m_forced);
  endtask

  initial begin
    // req, rel, grant, v, holder, forced
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[1]  = '{4'b1111, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0100, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0};
    tbl[8]  = '{4'b1001, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[9]  = '{4'b1001, 4'b1000, 4'b0000, 1'b0, 2'd3, 1'b0};
    tbl[10] = '{4'b1001, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0};
    tbl[11] = '{4'b1001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[12] = '{4'b1001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[13] = '{4'b1001, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{4'b1001, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[15] = '{4'b0100, 4'b1000, 4'b0000, 1'b0, 2'd3, 1'b0};
    tbl[16] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0};
    tbl[17] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};

    model_reset();
    req = 4'b1111;
    #2;
    checkOutput("reset_hold", 4'b0000, 1'b0, 2'd0, 1'b0);
    #10;
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].req, tbl[i].rel);
      checkOutput($sformatf("vec%0d", i), tbl[i].grant, tbl[i].v, tbl[i].holder, tbl[i].forced);
    end

`ifdef SWORD_ARB_TIMEOUT_EN
    for (int k = 0; k < HM - 1; k++) begin
      applyStimulus(4'b1000, 4'b0000);
      checkOutput("timeout_hold", 4'b0100, 1'b1, 2'd2, 1'b0);
    end
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("timeout_forced", 4'b0000, 1'b0, 2'd2, 1'b1);
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("timeout_idle", 4'b0000, 1'b0, 2'd2, 1'b0);
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("timeout_next", 4'b1000, 1'b1, 2'd3, 1'b0);
`else
    for (int k = 0; k < 50; k++) begin
      applyStimulus(4'b1000, 4'b0000);
      checkOutput("no_timeout_hold", 4'b0100, 1'b1, 2'd2, 1'b0);
    end
    applyStimulus(4'b1000, 4'b0100);
    checkOutput("late_release", 4'b0000, 1'b0, 2'd2, 1'b0);
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("late_idle", 4'b0000, 1'b0, 2'd2, 1'b0);
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("late_next", 4'b1000, 1'b1, 2'd3, 1'b0);
`endif

    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_mid_held", 4'b0000, 1'b0, 2'd0, 1'b0);
    model_reset();
    req = 4'b0100;
    rel = 4'b0000;
    #1;
    reset = 1'b1;
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("post_reset_grant", 4'b0100, 1'b1, 2'd2, 1'b0);

    for (int k = 0; k < 600; k++) begin
      logic [3:0] r, l;
      r = 4'($urandom_range(0, 15));
      l = 4'($urandom) & 4'($urandom);
      if ((k % 8) < 5) l = l & 4'($urandom);
      applyStimulus(r, l);
      checkModel("random");
      if ($urandom_range(0, 149) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checkModel("random_reset");
        #1;
        reset = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
